// File: rtl/routex_pkt_mux.sv
// Packet-atomic N:1 flit multiplexer. A round-robin arbiter locks onto one port
// for a whole packet and forwards its flits through a single output register.
module routex_pkt_mux #(
    parameter int NUMPORTS = 4,
    parameter int LANES    = 8,
    parameter int WIDTH    = 64
) (
    input  logic                                     CLK,
    input  logic                                     RST,
    input  logic [NUMPORTS-1:0][LANES-1:0][WIDTH-1:0] D,
    input  logic [NUMPORTS-1:0]                      D_VALID,
    input  logic [NUMPORTS-1:0]                      D_LAST,
    output logic [NUMPORTS-1:0]                      D_READY,
    output logic [LANES-1:0][WIDTH-1:0]              Q,
    output logic                                     Q_VALID,
    output logic                                     Q_LAST,
    input  logic                                     Q_READY,
    output logic [NUMPORTS-1:0]                      SRC_PORT,
    output logic                                     BUSY
);

    localparam int PW = (NUMPORTS > 1) ? $clog2(NUMPORTS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gnt_q, gnt_d;
    logic          req_found;
    logic [PW-1:0] req_idx;
    int            cand;
    logic          out_ready;
    logic          xfer;
    logic          xfer_last;

    // Round-robin search starting one past the last granted port.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NUMPORTS; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUMPORTS) cand = cand - NUMPORTS;
            if (!req_found && D_VALID[cand[PW-1:0]]) begin
                req_found = 1'b1;
                req_idx   = cand[PW-1:0];
            end
        end
    end

    // Handshakes: a flit moves on a port when VALID and READY are both high at
    // a rising edge; the output stage accepts whenever it is empty or draining.
    assign out_ready = !Q_VALID || Q_READY;
    assign xfer      = (state_q == LOCKED) && D_VALID[gnt_q] && out_ready;
    assign xfer_last = xfer && D_LAST[gnt_q];

    always_comb begin
        D_READY = '0;
        if (!RST && state_q == LOCKED) D_READY[gnt_q] = out_ready;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (req_found) begin
                    state_d = LOCKED;
                    gnt_d   = req_idx;
                end
            end
            LOCKED: begin
                if (xfer_last) begin
                    state_d = IDLE;
                    ptr_d   = gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NUMPORTS - 1);
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    // Output register: loads on transfer, holds under backpressure.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q       <= '0;
            Q_VALID <= 1'b0;
            Q_LAST  <= 1'b0;
        end else if (xfer) begin
            Q       <= D[gnt_q];
            Q_LAST  <= D_LAST[gnt_q];
            Q_VALID <= 1'b1;
        end else if (Q_READY) begin
            Q_VALID <= 1'b0;
        end
    end

    always_comb begin
        SRC_PORT = '0;
        if (state_q == LOCKED) SRC_PORT[gnt_q] = 1'b1;
    end

    assign BUSY = (state_q == LOCKED);

endmodule

// File: tb/tb_routex_pkt_mux.sv
// Bench for routex_pkt_mux: random packet sources, a packet-level reference
// model with a flit scoreboard, and directed grant-order / reset scenarios.
module tb_routex_pkt_mux;

    localparam int NP = 4;
    localparam int LN = 8;
    localparam int WD = 64;
    localparam int FW = LN * WD;
    localparam int CW = FW + 1;
    localparam int IW = $clog2(NP);

    logic                            CLK = 1'b0;
    logic                            RST = 1'b1;
    logic [NP-1:0][LN-1:0][WD-1:0]   D = '0;
    logic [NP-1:0]                   D_VALID = '0;
    logic [NP-1:0]                   D_LAST = '0;
    logic [NP-1:0]                   D_READY;
    logic [LN-1:0][WD-1:0]           Q;
    logic                            Q_VALID;
    logic                            Q_LAST;
    logic                            Q_READY = 1'b0;
    logic [NP-1:0]                   SRC_PORT;
    logic                            BUSY;

    routex_pkt_mux #(.NUMPORTS(NP), .LANES(LN), .WIDTH(WD)) dut (
        .CLK(CLK), .RST(RST), .D(D), .D_VALID(D_VALID), .D_LAST(D_LAST),
        .D_READY(D_READY), .Q(Q), .Q_VALID(Q_VALID), .Q_LAST(Q_LAST),
        .Q_READY(Q_READY), .SRC_PORT(SRC_PORT), .BUSY(BUSY)
    );

    // ---------------- clock / watchdog ----------------
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // ---------------- reference model + scoreboard + monitor ----------------
    bit              m_known = 1'b0;
    bit              m_busy;
    int              m_owner;
    int              m_ptr;
    bit              m_qv;
    logic [FW-1:0]   m_qd;
    bit              m_ql;
    logic [CW-1:0]   exp_q[$];
    logic [NP-1:0]   exp_rdy;
    logic [NP-1:0]   exp_src;
    logic [NP-1:0]   hs = '0;
    logic [NP-1:0]   prev_src = '0;
    int              cyc = 0;
    int              glog[$];
    int              gcyc[$];
    int              run_log[$];
    int              lastpos_log[$];
    int              run_len = 0;
    int              last_pos = 0;
    int              out_hs_cnt = 0;
    int              stall_bad = 0;

    always @(negedge CLK) begin
        logic [CW-1:0] front;
        bit            acc;
        int            gi;
        int            c;
        hs = D_VALID & D_READY;

        if (m_known) begin
            exp_rdy = '0;
            if (!RST && m_busy) exp_rdy[m_owner[IW-1:0]] = !m_qv || Q_READY;
            exp_src = '0;
            if (m_busy) exp_src[m_owner[IW-1:0]] = 1'b1;
            check("q_valid", CW'(Q_VALID), CW'(m_qv));
            check("busy", CW'(BUSY), CW'(m_busy));
            check("src_port", CW'(SRC_PORT), CW'(exp_src));
            check("d_ready", CW'(D_READY), CW'(exp_rdy));
            if (m_qv) begin
                check("q_data", CW'(Q), CW'(m_qd));
                check("q_last", CW'(Q_LAST), CW'(m_ql));
            end
            if (!RST && Q_VALID && Q_READY) begin
                out_hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", CW'(1), CW'(0));
                end else begin
                    front = exp_q.pop_front();
                    check("sb_flit", {Q_LAST, Q}, front);
                end
            end
        end

        // observation trace for directed expectations
        if (SRC_PORT != '0 && prev_src == '0) begin
            gi = -1;
            for (int i = 0; i < NP; i++) if (SRC_PORT[i]) gi = i;
            glog.push_back(gi);
            gcyc.push_back(cyc);
        end
        prev_src = SRC_PORT;
        if (Q_VALID) begin
            run_len++;
            if (Q_LAST && last_pos == 0) last_pos = run_len;
        end else if (run_len != 0) begin
            run_log.push_back(run_len);
            lastpos_log.push_back(last_pos);
            run_len  = 0;
            last_pos = 0;
        end
        if (Q_VALID && !Q_READY && D_READY != '0) stall_bad++;
        cyc++;

        // advance the model across the coming rising edge
        if (RST) begin
            m_known = 1'b1;
            m_busy  = 1'b0;
            m_owner = 0;
            m_ptr   = NP - 1;
            m_qv    = 1'b0;
            m_qd    = '0;
            m_ql    = 1'b0;
            exp_q.delete();
        end else if (m_known) begin
            acc = 1'b0;
            if (m_busy) begin
                if (D_VALID[m_owner[IW-1:0]] && (!m_qv || Q_READY)) begin
                    acc  = 1'b1;
                    m_qd = D[m_owner[IW-1:0]];
                    m_ql = D_LAST[m_owner[IW-1:0]];
                    m_qv = 1'b1;
                    exp_q.push_back({m_ql, m_qd});
                    if (m_ql) begin
                        m_busy = 1'b0;
                        m_ptr  = m_owner;
                    end
                end
            end else if (D_VALID != '0) begin
                for (int k = 1; k <= NP; k++) begin
                    c = (m_ptr + k) % NP;
                    if (!m_busy && D_VALID[c[IW-1:0]]) begin
                        m_busy  = 1'b1;
                        m_owner = c;
                    end
                end
            end
            if (!acc && Q_READY) m_qv = 1'b0;
        end
    end

    // ---------------- packet sources (driver) ----------------
    int            pkt_rem[NP];
    int            pkt_idx[NP];
    int            pkt_len[NP];
    logic [FW-1:0] cur_flit[NP];
    bit            gen_en   = 1'b0;
    bit            pat_mode = 1'b0;
    int            len_lo   = 1;
    int            len_hi   = 1;
    int            vpct     = 100;
    int            rpct     = 100;

    task automatic new_flit(input int p);
        cur_flit[p] = '0;
        if (pat_mode) begin
            cur_flit[p][WD-1:0] = (pkt_idx[p] == pkt_len[p] - 1) ? 64'd10 : {8'h2, 56'h0};
        end else begin
            for (int l = 0; l < LN; l++) cur_flit[p][l*WD +: WD] = {$urandom, $urandom};
        end
    endtask

    task automatic start_pkt(input int p, input int len);
        pkt_len[p] = len;
        pkt_idx[p] = 0;
        pkt_rem[p] = len;
        new_flit(p);
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            D[p]       = cur_flit[p];
            D_LAST[p]  = (pkt_rem[p] == 1);
            D_VALID[p] = (pkt_rem[p] > 0) && ($urandom_range(99) < vpct);
        end
        Q_READY = ($urandom_range(99) < rpct);
    endtask

    task automatic clear_src();
        for (int p = 0; p < NP; p++) begin
            pkt_rem[p]  = 0;
            pkt_idx[p]  = 0;
            pkt_len[p]  = 0;
            cur_flit[p] = '0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (hs[p]) begin
                pkt_rem[p]--;
                pkt_idx[p]++;
                if (pkt_rem[p] > 0) new_flit(p);
            end
            if (gen_en && pkt_rem[p] == 0) start_pkt(p, $urandom_range(len_hi, len_lo));
        end
        drive();
    endtask

    task automatic do_reset(input int n);
        RST    = 1'b1;
        gen_en = 1'b0;
        clear_src();
        drive();
        repeat (n) tick();
        RST = 1'b0;
    endtask

    function automatic bit any_pending();
        bit r = 1'b0;
        for (int p = 0; p < NP; p++) if (pkt_rem[p] > 0) r = 1'b1;
        return r;
    endfunction

    // ---------------- scenarios ----------------
    initial begin
        int g0, r0, o0, s0;
        int exp_seq[5];
        exp_seq = '{0, 1, 2, 3, 0};
        clear_src();

        // reset state
        do_reset(3);
        check("rst_q_valid", CW'(Q_VALID), CW'(0));
        check("rst_q_last", CW'(Q_LAST), CW'(0));
        check("rst_q", CW'(Q), CW'(0));
        check("rst_src_port", CW'(SRC_PORT), CW'(0));
        check("rst_busy", CW'(BUSY), CW'(0));
        check("rst_d_ready", CW'(D_READY), CW'(0));

        // ports 0 and 1 request together: 8-flit packet on 0, then 2-flit on 1
        g0 = glog.size(); r0 = run_log.size();
        pat_mode = 1'b1; vpct = 100; rpct = 100;
        start_pkt(0, 8); start_pkt(1, 2); drive();
        repeat (30) tick();
        if (glog.size() < g0 + 2) check("grant_count_a", CW'(glog.size()), CW'(g0 + 2));
        else begin
            check("first_grant", CW'(glog[g0]), CW'(0));
            check("second_grant", CW'(glog[g0+1]), CW'(1));
        end
        if (run_log.size() < r0 + 2) check("run_count_a", CW'(run_log.size()), CW'(r0 + 2));
        else begin
            check("pkt0_run_len", CW'(run_log[r0]), CW'(8));
            check("pkt0_last_pos", CW'(lastpos_log[r0]), CW'(8));
            check("pkt1_run_len", CW'(run_log[r0+1]), CW'(2));
        end
        pat_mode = 1'b0;

        // 3-cycle downstream stall in the middle of a 6-flit packet on port 2
        o0 = out_hs_cnt; s0 = stall_bad;
        start_pkt(2, 6); drive();
        repeat (3) tick();
        rpct = 0; drive();
        repeat (3) tick();
        rpct = 100; drive();
        repeat (12) tick();
        check("stall_flit_count", CW'(out_hs_cnt - o0), CW'(6));
        check("stall_ready_low", CW'(stall_bad - s0), CW'(0));

        // all ports stream single-flit packets: grants 0,1,2,3,0 two cycles apart
        do_reset(2);
        g0 = glog.size();
        gen_en = 1'b1; len_lo = 1; len_hi = 1;
        for (int p = 0; p < NP; p++) start_pkt(p, 1);
        drive();
        repeat (14) tick();
        gen_en = 1'b0;
        if (glog.size() < g0 + 5) check("grant_count_rr", CW'(glog.size()), CW'(g0 + 5));
        else begin
            for (int i = 0; i < 5; i++) check($sformatf("rr_grant_%0d", i), CW'(glog[g0+i]), CW'(exp_seq[i]));
            for (int i = 1; i < 5; i++) check($sformatf("rr_gap_%0d", i), CW'(gcyc[g0+i] - gcyc[g0+i-1]), CW'(2));
        end
        repeat (12) tick();

        // reset pulse in the middle of a packet on port 3
        do_reset(1);
        o0 = out_hs_cnt;
        start_pkt(3, 6); drive();
        for (int i = 0; i < 20 && (out_hs_cnt - o0) < 3; i++) tick();
        check("mid_pkt_reached", CW'((out_hs_cnt - o0) >= 3), CW'(1));
        RST = 1'b1; clear_src(); drive();
        tick();
        RST = 1'b0; drive();
        check("rst_mid_q_valid", CW'(Q_VALID), CW'(0));
        check("rst_mid_busy", CW'(BUSY), CW'(0));
        g0 = glog.size();
        for (int p = 0; p < NP; p++) start_pkt(p, 2);
        drive();
        repeat (20) tick();
        if (glog.size() < g0 + 1) check("grant_count_rst", CW'(glog.size()), CW'(g0 + 1));
        else check("rst_first_grant", CW'(glog[g0]), CW'(0));

        // randomized traffic with bubbles and backpressure
        gen_en = 1'b1; len_lo = 1; len_hi = 5; vpct = 70; rpct = 70;
        repeat (3000) tick();

        // drain
        gen_en = 1'b0; vpct = 100; rpct = 100; drive();
        for (int i = 0; i < 300 && (any_pending() || exp_q.size() != 0); i++) tick();
        repeat (3) tick();
        check("drain_pending", CW'(any_pending()), CW'(0));
        check("sb_drain", CW'(exp_q.size()), CW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
